// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and the shift-amount helper
// used by the multi-cycle ALU.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_ADD2 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Shift field encodes amount minus one, giving 1..4.
  function automatic logic [2:0] shift_amt(input logic [1:0] f);
    return {1'b0, f} + 3'd1;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle of the multi-cycle ALU.
interface seq_alu_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       alu_op;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;

  modport master (
    output in_valid, A, B, alu_op, abort, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c
  );

  modport slave (
    input  in_valid, A, B, alu_op, abort, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c
  );
endinterface

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module seq_alu_mul #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod_nxt
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               run;

  // mcand is A pre-shifted by the step index, so each step is a plain add.
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign done     = run && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      prod   <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CNT_W'(WIDTH);
      run    <= 1'b1;
    end else if (abort) begin
      run    <= 1'b0;
    end else if (run) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shifts and a
// shift-add multiplier behind valid/ready handshakes on both sides.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   result_q;
  logic               z_q, n_q, c_q;

  logic               accept;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   shift_nxt;
  logic               shift_out;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               fin_load;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c;

  // abort wins over a same-cycle request
  assign accept = (state == ST_IDLE) && bus.in_valid && !bus.abort;
  assign sum    = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff   = {1'b0, bus.A} - {1'b0, bus.B};

  assign shift_nxt = (op_q == OP_SHL) ? (acc << 1) : (acc >> 1);
  assign shift_out = (op_q == OP_SHL) ? acc[WIDTH-1] : acc[0];

  seq_alu_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && (bus.alu_op[2:0] == OP_MUL)),
    .abort    (bus.abort),
    .a        (bus.A),
    .b        (bus.B),
    .done     (mul_done),
    .prod_nxt (mul_prod)
  );

  // Final result of whichever path completes this cycle.
  always_comb begin
    fin_load = 1'b0;
    fin_res  = result_q;
    fin_c    = c_q;
    case (state)
      ST_IDLE: if (accept) begin
        case (bus.alu_op[2:0])
          OP_SUB: begin fin_load = 1'b1; fin_res = diff[WIDTH-1:0]; fin_c = diff[WIDTH]; end
          OP_AND: begin fin_load = 1'b1; fin_res = bus.A & bus.B; fin_c = 1'b0; end
          OP_OR:  begin fin_load = 1'b1; fin_res = bus.A | bus.B; fin_c = 1'b0; end
          OP_SHL, OP_SHR, OP_MUL: fin_load = 1'b0;
          default: begin fin_load = 1'b1; fin_res = sum[WIDTH-1:0]; fin_c = sum[WIDTH]; end
        endcase
      end
      ST_BUSY: if (!bus.abort) begin
        if (op_q == OP_MUL) begin
          if (mul_done) begin
            fin_load = 1'b1;
            fin_res  = mul_prod[WIDTH-1:0];
            fin_c    = |mul_prod[2*WIDTH-1:WIDTH];
          end
        end else if (cnt == CNT_W'(1)) begin
          fin_load = 1'b1;
          fin_res  = shift_nxt;
          fin_c    = shift_out;
        end
      end
      default: fin_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op_q <= bus.alu_op[2:0];
          case (bus.alu_op[2:0])
            OP_SHL, OP_SHR: begin
              acc   <= bus.A;
              cnt   <= CNT_W'(shift_amt(bus.alu_op[4:3]));
              state <= ST_BUSY;
            end
            OP_MUL:  state <= ST_BUSY;
            default: state <= ST_DONE;
          endcase
        end
        ST_BUSY: begin
          if (bus.abort) begin
            state <= ST_IDLE;
          end else if (op_q == OP_MUL) begin
            if (mul_done) state <= ST_DONE;
          end else begin
            acc <= shift_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: if (bus.abort || bus.out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (fin_load) begin
        result_q <= fin_res;
        c_q      <= fin_c;
        z_q      <= (fin_res == '0);
        n_q      <= fin_res[WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = result_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): vector table through a
// scoreboard queue, plus hand-written abort and reset sequences.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(8)) bus();

  seq_alu #(.WIDTH(8), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // lat = negedges after the accept edge until out_valid is seen
  typedef struct {
    logic [7:0] res;
    logic       z, n, c;
    int         lat;
  } exp_t;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a, b;
    exp_t       e;
    int         hold;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] res, input logic z, input logic n,
                              input logic c, input int lat, input int hold);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hold = hold;
    v.e.res = res; v.e.z = z; v.e.n = n; v.e.c = c; v.e.lat = lat;
    return v;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Present a request at a negedge; returns after the accept edge and
  // scrambles the inputs so any late sampling of them shows up.
  task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = a; bus.B = b; bus.alu_op = op;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = 8'($urandom); bus.B = 8'($urandom); bus.alu_op = 5'($urandom);
  endtask

  task automatic do_op(input vec_t v);
    int   lat;
    exp_t x;
    sbq.push_back(v.e);
    bus.out_ready = 1'b0;
    issue(v.op, v.a, v.b);
    wait_valid(lat);
    if (!bus.out_valid) begin
      chk("timeout_out_valid", 32'(bus.out_valid), 32'd1);
      void'(sbq.pop_front());
    end else begin
      x = sbq.pop_front();
      chk("result", 32'(bus.result), 32'(x.res));
      chk("flag_z", 32'(bus.flag_z), 32'(x.z));
      chk("flag_n", 32'(bus.flag_n), 32'(x.n));
      chk("flag_c", 32'(bus.flag_c), 32'(x.c));
      chk("latency", 32'(lat), 32'(x.lat));
      repeat (v.hold) begin
        @(negedge clk);
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("hold_result", 32'(bus.result), 32'(x.res));
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int rises;

    vecs.push_back(mk(5'b00000, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0, 0)); // ADD wrap
    vecs.push_back(mk(5'b00001, 8'h05, 8'h07, 8'hFE, 0, 1, 1, 0, 5)); // SUB borrow, stall
    vecs.push_back(mk(5'b11100, 8'h81, 8'h00, 8'h10, 0, 0, 0, 4, 0)); // SHL k=4
    vecs.push_back(mk(5'b00101, 8'h81, 8'h00, 8'h40, 0, 0, 1, 1, 0)); // SHR k=1
    vecs.push_back(mk(5'b00110, 8'h0F, 8'h11, 8'hFF, 0, 1, 0, 8, 0)); // MUL
    vecs.push_back(mk(5'b00110, 8'h10, 8'h10, 8'h00, 1, 0, 1, 8, 0)); // MUL overflow
    vecs.push_back(mk(5'b00110, 8'hFF, 8'hFF, 8'h01, 0, 0, 1, 8, 1)); // MUL max
    vecs.push_back(mk(5'b00010, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0)); // AND
    vecs.push_back(mk(5'b00011, 8'hA0, 8'h05, 8'hA5, 0, 1, 0, 0, 0)); // OR
    vecs.push_back(mk(5'b00111, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0, 0)); // op 7 = ADD
    vecs.push_back(mk(5'b00001, 8'h07, 8'h07, 8'h00, 1, 0, 0, 0, 0)); // SUB equal
    vecs.push_back(mk(5'b10101, 8'h0C, 8'h00, 8'h01, 0, 0, 1, 3, 0)); // SHR k=3
    vecs.push_back(mk(5'b01100, 8'h40, 8'h00, 8'h00, 1, 0, 1, 2, 0)); // SHL k=2

    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.alu_op = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;

    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // abort three cycles into a multiply
    issue(5'b00110, 8'h0F, 8'h11);
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_busy_valid", 32'(bus.out_valid), 32'd0);
    rises = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) rises++;
    end
    chk("abort_no_valid", 32'(rises), 32'd0);
    do_op(mk(5'b00000, 8'h02, 8'h03, 8'h05, 0, 0, 0, 0, 0));

    // abort in IDLE blocks a same-cycle request
    @(negedge clk);
    bus.in_valid = 1'b1; bus.abort = 1'b1;
    bus.A = 8'h11; bus.B = 8'h22; bus.alu_op = 5'b00000;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.abort = 1'b0;
    chk("abort_idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_idle_valid", 32'(bus.out_valid), 32'd0);

    // abort while DONE keeps the last result
    issue(5'b00010, 8'hF0, 8'h3C);
    wait_valid(lat);
    chk("done_seen", 32'(bus.out_valid), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_done_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_done_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_done_result", 32'(bus.result), 32'h30);

    // asynchronous reset two cycles into a shift
    issue(5'b11100, 8'h81, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(mk(5'b00011, 8'hA0, 8'h05, 8'hA5, 0, 1, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational ALU in the single-cycle core.
- Adds WIDTH generalisation, iterative 1-bit-per-cycle shifts in both directions, and a shift-add multiplier.
- Adds status flags and a valid/ready handshake on both the operand and the result side.
- Intended for the multi-cycle core datapath; it stalls the controller through in_ready and out_valid.

Parameters:
- WIDTH, 8, operand and result width in bits (>=4).
- CNT_W, 6, width of the internal cycle counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept a request
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- alu_op  in  5  [2:0] opcode; [4:3] shift amount minus 1
- abort  in  1  synchronous cancel of the operation in flight
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  registered result
- flag_z  out  1  result == 0
- flag_n  out  1  result[WIDTH-1]
- flag_c  out  1  carry/borrow/shift-out/overflow (per opcode)

Behaviour:
- Opcodes (alu_op[2:0]):
  - 000 ADD; C = carry out.
  - 001 SUB (A-B); C = borrow (A<B unsigned).
  - 010 AND; C = 0.
  - 011 OR; C = 0.
  - 100 SHL by k=alu_op[4:3]+1; C = last bit shifted out.
  - 101 SHR logical by k; C = last bit shifted out.
  - 110 MUL unsigned; result = low WIDTH bits; C = |high WIDTH bits.
  - 111 treated as ADD.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterative shift or multiply.
  - DONE: out_valid=1.
- Accept happens when in_valid && in_ready. A, B and alu_op are latched that cycle, so later input changes are ignored.
- ADD/SUB/AND/OR: result and flags registered at the accept edge; IDLE->DONE. out_valid is high the cycle after accept (latency 1).
- SHL/SHR: accumulator=A, counter=k, IDLE->BUSY.
  - Each BUSY cycle shifts by 1 and decrements the counter.
  - The final shift moves BUSY->DONE.
  - out_valid is high k cycles after accept (1..4).
- MUL: 2*WIDTH-bit product register cleared, multiplier=B, counter=WIDTH, IDLE->BUSY.
  - Each BUSY cycle: if multiplier LSB is set, add A shifted left by the step index; then shift the multiplier right.
  - out_valid is high WIDTH cycles after accept.
- DONE: result and flags held stable while out_valid && !out_ready. On out_ready, DONE->IDLE.
  - in_ready is low in DONE, so there is no overlap.
  - Next accept is possible the cycle after the handshake, giving a minimum request-to-request spacing of 2 cycles.
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state.
- flag_z and flag_n are derived from the final WIDTH-bit result only.
- abort:
  - In BUSY or DONE: next state is IDLE, out_valid drops, and result/flags keep their last values.
  - In IDLE: no effect; abort has priority over in_valid that same cycle, so no accept occurs.
- rst_n low, at any time including mid-operation: state=IDLE, and result, flags, counter, accumulator and product all clear to 0.
  - out_valid=0 immediately; in_ready=1 immediately (asynchronous).
- All arithmetic is modulo 2**WIDTH. There is no signed overflow flag.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL (3-bit);
  - state encoding ST_IDLE/ST_BUSY/ST_DONE;
  - a function computing shift amount k from alu_op[4:3].
- One sub-module: seq_alu_mul, the shift-add multiplier datapath (start, done, WIDTH-parametrised). The top module owns the FSM, the shifter and the single-cycle ops.

Test Plan (WIDTH=8):
- ADD A=0xFF B=0x01, out_ready=1 -> out_valid 1 cycle after accept; result=0x00, Z=1, C=1, N=0.
- SUB A=0x05 B=0x07 -> result=0xFE, C=1, N=1, Z=0. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0 throughout.
- SHL alu_op=5'b11100 A=0x81 -> out_valid 4 cycles after accept; result=0x10, C=0. SHR alu_op=5'b00101 A=0x81 -> 1 cycle; result=0x40, C=1.
- MUL A=0x0F B=0x11 -> out_valid 8 cycles after accept; result=0xFF, C=0. MUL A=0x10 B=0x10 -> result=0x00, Z=1, C=1.
- Abort: assert abort 3 cycles into MUL -> IDLE next cycle, out_valid never rises. A following ADD 0x02+0x03 returns 0x05.
- Reset: pull rst_n low 2 cycles into SHL -> outputs 0 and in_ready=1 asynchronously. After release, OR 0xA0|0x05 -> 0xA5, N=1.
